tff_counter_ctrl: RTL

- Sequencing controller for a WIDTH-bit bank of toggle flip-flop cells, forming a programmable modulo-(limit+1) counter.
- Computes each cell's T (toggle) input every cycle from current state, count value and command inputs; the register state is held only in the toggle cells.
- Provides start/stop control, one-shot or auto-reload operation, and a terminal-count pulse.
- Used as a timebase / clock-enable generator beside the existing flip-flop primitives.

---
 rtl/tff_ctrl_pkg.sv | 32 +++
 rtl/tff_cell.sv | 21 ++
 rtl/tff_counter_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/tff_ctrl_pkg.sv
// Shared types and helpers for the toggle-cell counter controller.
package tff_ctrl_pkg;

   localparam int MAX_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Toggle vector that adds one: cell i flips when every lower cell is 1.
   function automatic logic [MAX_WIDTH-1:0] inc_tvec(input logic [MAX_WIDTH-1:0] q);
      logic [MAX_WIDTH-1:0] t;
      t[0] = 1'b1;
      for (int i = 1; i < MAX_WIDTH; i++) begin
         t[i] = t[i-1] & q[i-1];
      end
      return t;
   endfunction

   // Toggle vector that subtracts one: cell i flips when every lower cell is 0.
   function automatic logic [MAX_WIDTH-1:0] dec_tvec(input logic [MAX_WIDTH-1:0] q);
      logic [MAX_WIDTH-1:0] t;
      t[0] = 1'b1;
      for (int i = 1; i < MAX_WIDTH; i++) begin
         t[i] = t[i-1] & ~q[i-1];
      end
      return t;
   endfunction

endpackage

// File: rtl/tff_cell.sv
// Single toggle flip-flop: q flips on a rising clock edge whenever t is high.
module tff_cell (
   input  logic clk,
   input  logic clear_n,
   input  logic t,
   output logic q
);

   logic q_q;

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_q ^ t;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/tff_counter_ctrl.sv
// Modulo-(limit+1) counter built from a bank of toggle cells; the controller only drives T inputs.
// Optional down-counting (dir port) is enabled by defining TFF_COUNTER_DOWN_EN.
module tff_counter_ctrl
   import tff_ctrl_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             start,
   input  logic             stop,
   input  logic             auto_reload,
   input  logic [WIDTH-1:0] limit,
`ifdef TFF_COUNTER_DOWN_EN
   input  logic             dir,
`endif
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] t_vec,
   output logic             busy,
   output logic             done,
   output logic             tc
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] limit_q, limit_d;
   logic             reload_q, reload_d;
   logic             tc_q, tc_d;

   logic             go;
   logic             term;
   logic [WIDTH-1:0] t_step;
   logic [WIDTH-1:0] t_start;
   logic [WIDTH-1:0] t_term;

   assign go = start & ~stop;

`ifdef TFF_COUNTER_DOWN_EN
   logic dir_q, dir_d;

   // Down mode starts from limit, terminates at zero and reloads limit on wrap.
   assign term    = dir_q ? (count == '0) : (count == limit_q);
   assign t_step  = dir_q ? WIDTH'(dec_tvec(MAX_WIDTH'(count)))
                          : WIDTH'(inc_tvec(MAX_WIDTH'(count)));
   assign t_start = dir ? (count ^ limit) : count;
   assign t_term  = (dir_q && reload_q) ? (count ^ limit_q) : count;
`else
   assign term    = (count == limit_q);
   assign t_step  = WIDTH'(inc_tvec(MAX_WIDTH'(count)));
   assign t_start = count;
   assign t_term  = count;
`endif

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_q  <= IDLE;
         limit_q  <= '0;
         reload_q <= 1'b0;
         tc_q     <= 1'b0;
`ifdef TFF_COUNTER_DOWN_EN
         dir_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         limit_q  <= limit_d;
         reload_q <= reload_d;
         tc_q     <= tc_d;
`ifdef TFF_COUNTER_DOWN_EN
         dir_q    <= dir_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      limit_d  = limit_q;
      reload_d = reload_q;
      tc_d     = 1'b0;
`ifdef TFF_COUNTER_DOWN_EN
      dir_d    = dir_q;
`endif
      unique case (state_q)
         IDLE, DONE: begin
            if (go) begin
               state_d  = RUN;
               limit_d  = limit;
               reload_d = auto_reload;
`ifdef TFF_COUNTER_DOWN_EN
               dir_d    = dir;
`endif
            end else if (stop) begin
               state_d = IDLE;
            end
         end
         RUN: begin
            // stop outranks the terminal-count event
            if (stop) begin
               state_d = IDLE;
            end else if (term) begin
               tc_d = 1'b1;
               if (!reload_q) begin
                  state_d = DONE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      busy  = (state_q == RUN);
      done  = (state_q == DONE);
      t_vec = '0;
      unique case (state_q)
         IDLE, DONE: begin
            if (go) begin
               t_vec = t_start;
            end
         end
         RUN: begin
            if (stop) begin
               t_vec = count;
            end else if (term) begin
               t_vec = t_term;
            end else begin
               t_vec = t_step;
            end
         end
         default: begin
            t_vec = count;
         end
      endcase
   end

   assign tc = tc_q;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      tff_cell u_cell (
         .clk     (clk),
         .clear_n (clear_n),
         .t       (t_vec[i]),
         .q       (count[i])
      );
   end

endmodule
